pdpu_dot_seq: RTL and testbench

//  Sequences a long posit dot-product (len_i chunks of N element pairs) through one internal

---
 rtl/pdpu_dot_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_pdpu_dot_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdpu_dot_seq.sv
// pdpu_dot_seq: walks a long posit dot product through one pdpu_top, one chunk of
// N element pairs per cycle, feeding each result back in as the accumulator.
// The accumulator is seeded with a bias. NaR is tracked stickily. The final
// posit(n_o,es_o) value is returned over a valid/ready handshake.
//
// Ports (pdpu_dot_seq):
//   clk_i, rst_i              clock, synchronous active-high reset
//   start_i, len_i, bias_i    job start; chunk count and seed sampled with start_i in IDLE
//   abort_i                   drop the current job and return to IDLE
//   in_valid_i/in_ready_o     chunk handshake; in_a_i/in_b_i hold N packed n_i-bit posits
//   out_valid_o/out_ready_i   result handshake; out_data_o is the posit(n_o,es_o) result
//   busy_o                    high outside IDLE
//
// State   | meaning
// IDLE    | waiting for start_i
// ACCUM   | accepting chunks; cnt_q chunks still to come
// DONE    | result presented until out_ready_i

// pdpu_top: exact fused dot product plus accumulate, with a single round-to-nearest-even
// into posit(n_o,es_o). Inputs are posit(n_i,es_i).
// Ports: operands_a/operands_b (N packed posits), acc (posit n_o), result_o (posit n_o).
module pdpu_top #(
    parameter int N = 4, parameter int n_i = 8, parameter int es_i = 2,
    parameter int n_o = 16, parameter int es_o = 2, parameter int ALIGN_WIDTH = 14
) (
    input  logic [N*n_i-1:0] operands_a,
    input  logic [N*n_i-1:0] operands_b,
    input  logic [n_o-1:0]   acc,
    output logic [n_o-1:0]   result_o
);
    // Every term is placed on one fixed-point grid whose LSB is 2^-OFF. The grid is
    // wide enough that the sum is exact, so only the final encode rounds.
    localparam int FW      = n_o - 3;
    localparam int MAX_SI  = (n_i - 2) << es_i;
    localparam int MAX_SO  = (n_o - 2) << es_o;
    localparam int OFF     = (2*MAX_SI + 2*FW > MAX_SO + FW) ? 2*MAX_SI + 2*FW : MAX_SO + FW;
    localparam int TOP     = (2*MAX_SI + 2 > MAX_SO + 1) ? 2*MAX_SI + 2 : MAX_SO + 1;
    localparam int EXACT_W = TOP + OFF + $clog2(N + 1) + 2;
    localparam int W       = (EXACT_W > ALIGN_WIDTH) ? EXACT_W : ALIGN_WIDTH;
    localparam int BW      = W + n_o + es_o + 2;

    typedef struct packed {
        logic               zero;
        logic               nar;
        logic               sign;
        logic signed [15:0] scale;
        logic [FW:0]        mant;   // 1.f, value = mant * 2^(scale-FW)
    } dec_t;

    // Decodes an n_o-bit posit with the given es. Narrower inputs are left-aligned,
    // because zero-padding a posit keeps its value.
    function automatic dec_t decode(input logic [n_o-1:0] p, input int es);
        dec_t           d;
        logic [n_o-2:0] r, rem, ev, fr;
        int             run, k;
        d      = '0;
        d.zero = (p == '0);
        d.nar  = (p == {1'b1, {(n_o-1){1'b0}}});
        d.sign = p[n_o-1];
        r      = p[n_o-2:0];
        if (p[n_o-1]) r = -r;
        run = 1;
        for (int i = n_o - 3; i >= 0; i--)
            if (r[i] == r[n_o-2] && run == n_o - 2 - i) run++;
        k       = r[n_o-2] ? run - 1 : -run;
        rem     = r << (run + 1);
        ev      = rem >> (n_o - 1 - es);
        fr      = rem << es;
        d.scale = 16'(k * (1 << es) + int'(ev));
        d.mant  = {1'b1, fr[n_o-2 -: FW]};
        return d;
    endfunction

    always_comb begin
        dec_t              da, pa, pb;
        logic [W-1:0]      sum, term, mag;
        logic [W-2:0]      frac_v;
        logic [n_o-1:0]    wa, wb;
        logic [BW-1:0]     body;
        logic [es_o-1:0]   e_bits;
        logic [n_o-2:0]    res;
        logic [n_o-1:0]    rs;
        logic              any_nar, rnd;
        int                msb, scale, k, rlen;
        sum = '0; term = '0; any_nar = 1'b0;
        da = decode(acc, es_o);
        any_nar = da.nar;
        if (!da.zero && !da.nar) begin
            term = W'(da.mant) << (int'(da.scale) - FW + OFF);
            sum  = da.sign ? -term : term;
        end
        for (int i = 0; i < N; i++) begin
            wa = n_o'(operands_a[i*n_i +: n_i]) << (n_o - n_i);
            wb = n_o'(operands_b[i*n_i +: n_i]) << (n_o - n_i);
            pa = decode(wa, es_i);
            pb = decode(wb, es_i);
            if (pa.nar || pb.nar) any_nar = 1'b1;
            if (!pa.zero && !pb.zero && !pa.nar && !pb.nar) begin
                term = (W'(pa.mant) * W'(pb.mant)) << (int'(pa.scale) + int'(pb.scale) - 2*FW + OFF);
                sum  = (pa.sign ^ pb.sign) ? sum - term : sum + term;
            end
        end

        mag = sum[W-1] ? -sum : sum;
        msb = 0;
        for (int i = 0; i < W; i++) if (mag[i]) msb = i;
        scale  = msb - OFF;
        k      = scale >>> es_o;
        e_bits = es_o'(scale);
        rlen   = (k >= 0) ? k + 2 : 1 - k;
        frac_v = (W-1)'(mag << (W - 1 - msb));
        // Unbounded posit string: regime, exponent, fraction; then cut and round.
        body = {e_bits, frac_v, {(n_o+3){1'b0}}} >> rlen;
        if (k >= 0) body = body | ~({BW{1'b1}} >> (k + 1));
        else        body[BW - rlen] = 1'b1;
        res = body[BW-1 -: n_o-1];
        rnd = body[BW-n_o] & ((|body[BW-n_o-1:0]) | res[0]);
        // Posits saturate: never round to zero or past maxpos.
        if (scale >= MAX_SO)      rs = {1'b0, {(n_o-1){1'b1}}};
        else if (scale < -MAX_SO) rs = n_o'(1);
        else                      rs = {1'b0, res} + n_o'(rnd);

        if (any_nar)       result_o = {1'b1, {(n_o-1){1'b0}}};
        else if (mag == 0) result_o = '0;
        else               result_o = sum[W-1] ? -rs : rs;
    end
endmodule

module pdpu_dot_seq #(
    parameter int N = 4, parameter int n_i = 8, parameter int es_i = 2,
    parameter int n_o = 16, parameter int es_o = 2,
    parameter int ALIGN_WIDTH = 14, parameter int LEN_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [n_o-1:0]       bias_i,
    input  logic                 abort_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [N*n_i-1:0]     in_a_i,
    input  logic [N*n_i-1:0]     in_b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [n_o-1:0]       out_data_o,
    output logic                 busy_o
);
    localparam logic [n_o-1:0] NAR_O = {1'b1, {(n_o-1){1'b0}}};
    localparam logic [n_i-1:0] NAR_I = {1'b1, {(n_i-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t               state_q, state_d;
    logic [n_o-1:0]       acc_q, acc_d, pdpu_res;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic                 nar_q, nar_d, chunk_nar;
    logic [N*n_i-1:0]     op_a, op_b;

    // Operands are held at zero outside ACCUM so the datapath does not toggle.
    assign op_a = (state_q == ACCUM) ? in_a_i : '0;
    assign op_b = (state_q == ACCUM) ? in_b_i : '0;

    pdpu_top #(.N(N), .n_i(n_i), .es_i(es_i), .n_o(n_o), .es_o(es_o), .ALIGN_WIDTH(ALIGN_WIDTH))
        u_pdpu (.operands_a(op_a), .operands_b(op_b), .acc(acc_q), .result_o(pdpu_res));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            nar_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            nar_q   <= nar_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        nar_d       = nar_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        busy_o      = (state_q != IDLE);
        chunk_nar   = 1'b0;
        for (int i = 0; i < N; i++)
            if (in_a_i[i*n_i +: n_i] == NAR_I || in_b_i[i*n_i +: n_i] == NAR_I) chunk_nar = 1'b1;

        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            nar_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    acc_d   = bias_i;
                    cnt_d   = len_i;
                    nar_d   = (bias_i == NAR_O);
                    state_d = (len_i != '0) ? ACCUM : DONE;
                end
                ACCUM: begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        acc_d = pdpu_res;
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                        nar_d = nar_q | chunk_nar;
                        if (cnt_q == LEN_WIDTH'(1)) state_d = DONE;
                    end
                end
                DONE: begin
                    out_valid_o = 1'b1;
                    out_data_o  = nar_q ? NAR_O : acc_q;
                    if (out_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pdpu_dot_seq.sv
module tb_pdpu_dot_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [7:0]  len = '0;
    logic [15:0] bias = '0;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_data;

    int n_tests = 0, n_fail = 0, last_rdy = 0;
    logic [31:0] job_a[$], job_b[$];

    pdpu_dot_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len), .bias_i(bias),
        .abort_i(abort), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) repeat (e) r = r * 2.0;
        else        repeat (-e) r = r / 2.0;
        return r;
    endfunction

    // Real value of an n-bit posit(n,es) held in the low bits of p (NaR not expected).
    function automatic real p2r(input logic [15:0] p, input int n, input int es);
        logic [15:0] x, mask;
        int i, run, k, e;
        logic first, s;
        real f, w, v;
        mask = 16'hffff >> (16 - n);
        x = p & mask;
        if (x == 0) return 0.0;
        s = x[n-1];
        if (s) x = (~x + 16'd1) & mask;
        i = n - 2; first = x[i]; run = 0;
        while (i >= 0 && x[i] == first) begin run++; i--; end
        k = first ? run - 1 : -run;
        i--;
        e = 0;
        for (int j = 0; j < es; j++) begin
            e = e * 2 + ((i >= 0) ? int'(x[i]) : 0);
            i--;
        end
        f = 1.0; w = 0.5;
        while (i >= 0) begin
            if (x[i]) f = f + w;
            w = w / 2.0; i--;
        end
        v = f * pow2(k * (1 << es) + e);
        return s ? -v : v;
    endfunction

    // Nearest posit(16,2) to x, ties to the even pattern, saturating at minpos/maxpos.
    function automatic logic [15:0] r2p16(input real x);
        real ax, v0, v1, mid;
        int lo, hi, m;
        logic [15:0] p;
        if (x == 0.0) return 16'h0000;
        ax = (x < 0.0) ? -x : x;
        if (ax >= p2r(16'h7fff, 16, 2))      p = 16'h7fff;
        else if (ax <= p2r(16'h0001, 16, 2)) p = 16'h0001;
        else begin
            lo = 1; hi = 32'h7fff;
            while (hi - lo > 1) begin
                m = (lo + hi) / 2;
                if (p2r(16'(m), 16, 2) <= ax) lo = m; else hi = m;
            end
            v0 = p2r(16'(lo), 16, 2); v1 = p2r(16'(hi), 16, 2); mid = (v0 + v1) / 2.0;
            if (ax < mid)      p = 16'(lo);
            else if (ax > mid) p = 16'(hi);
            else               p = lo[0] ? 16'(hi) : 16'(lo);
        end
        return (x < 0.0) ? -p : p;
    endfunction

    function automatic logic [15:0] model_job(input logic [15:0] bias_v);
        logic [15:0] accp;
        logic nar;
        real s;
        accp = bias_v;
        nar  = (bias_v == 16'h8000);
        foreach (job_a[c]) begin
            for (int i = 0; i < 4; i++)
                if (job_a[c][i*8 +: 8] == 8'h80 || job_b[c][i*8 +: 8] == 8'h80) nar = 1'b1;
            if (!nar) begin
                s = p2r(accp, 16, 2);
                for (int i = 0; i < 4; i++)
                    s = s + p2r({8'h00, job_a[c][i*8 +: 8]}, 8, 2) * p2r({8'h00, job_b[c][i*8 +: 8]}, 8, 2);
                accp = r2p16(s);
            end
        end
        return nar ? 16'h8000 : accp;
    endfunction

    function automatic logic [7:0] rand_p8();
        logic [7:0] r;
        real v;
        if ($urandom_range(49) == 0) return 8'h80;
        for (int t = 0; t < 64; t++) begin
            r = 8'($urandom_range(255));
            if (r == 8'h00) return r;
            if (r != 8'h80) begin
                v = p2r({8'h00, r}, 8, 2);
                if (v < 0.0) v = -v;
                if (v >= pow2(-6) && v <= pow2(6)) return r;
            end
        end
        return 8'h40;
    endfunction

    function automatic logic [15:0] rand_bias();
        logic [15:0] r;
        real v;
        if ($urandom_range(5) == 0) return 16'h0000;
        for (int t = 0; t < 64; t++) begin
            r = 16'($urandom_range(65535));
            if (r != 16'h8000 && r != 16'h0000) begin
                v = p2r(r, 16, 2);
                if (v < 0.0) v = -v;
                if (v >= pow2(-6) && v <= pow2(12)) return r;
            end
        end
        return 16'h4000;
    endfunction

    task automatic fill_const(input int n, input logic [31:0] a, input logic [31:0] b);
        job_a.delete(); job_b.delete();
        repeat (n) begin job_a.push_back(a); job_b.push_back(b); end
    endtask

    // Runs the queued chunks as one job; called and returns at a falling edge.
    task automatic run_job(input string tag, input logic [15:0] bias_v, input int gap_pct,
                           input int hold, input logic pulse_start, input logic [15:0] exp);
        int idx, cyc, rdy_cnt;
        logic [15:0] first;
        logic stable;
        start = 1'b1; len = 8'(job_a.size()); bias = bias_v;
        @(negedge clk);
        start = 1'b0; idx = 0; cyc = 0; rdy_cnt = 0;
        while (idx < job_a.size() && cyc < 300) begin
            if (int'($urandom_range(99)) < gap_pct) in_valid = 1'b0;
            else begin in_valid = 1'b1; in_a = job_a[idx]; in_b = job_b[idx]; end
            #1;
            if (in_ready) begin
                rdy_cnt++;
                if (in_valid) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_a = '0; in_b = '0;
        last_rdy = rdy_cnt;
        chk({tag, "_fed"}, idx, job_a.size());
        chk({tag, "_valid"}, {31'd0, out_valid}, 1);
        first = out_data; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (pulse_start) begin start = 1'b1; len = 8'd5; bias = 16'h1234; end
            @(negedge clk);
            start = 1'b0;
            if (!out_valid || out_data !== first || in_ready) stable = 1'b0;
        end
        chk({tag, "_stable"}, {31'd0, stable}, 1);
        chk({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_idle"}, {29'd0, out_valid, busy, in_ready}, 0);
    endtask

    initial begin
        logic [15:0] b, e;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_outs", {13'd0, in_ready, out_valid, busy, out_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", {13'd0, in_ready, out_valid, busy, out_data}, 0);

        fill_const(1, 32'h40404040, 32'h40404040);
        run_job("t1", 16'h0000, 0, 0, 1'b0, 16'h5000);
        fill_const(2, 32'h40404040, 32'h40404040);
        run_job("t2", 16'h0000, 0, 0, 1'b0, 16'h5800);
        chk("t2_rdy_cycles", last_rdy, 2);
        fill_const(1, 32'h40404040, 32'h40404040);
        run_job("t3", 16'h4000, 0, 0, 1'b0, 16'h5200);
        fill_const(0, 32'h0, 32'h0);
        run_job("t3_len0", 16'h4000, 0, 1, 1'b0, 16'h4000);

        fill_const(3, 32'h40404040, 32'h40404040);
        job_a[1] = 32'h40408040;
        run_job("t4_nar", 16'h0000, 0, 0, 1'b0, 16'h8000);

        fill_const(3, 32'h40404040, 32'h40404040);
        run_job("t5_bp", 16'h0000, 50, 5, 1'b1, 16'h5c00);

        // Abort in ACCUM after one chunk, with a chunk offered in the abort cycle.
        start = 1'b1; len = 8'd3; bias = 16'h0000;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 32'h40404040; in_b = 32'h40404040;
        @(negedge clk);
        abort = 1'b1;
        #1;
        chk("t6_abort_rdy", {31'd0, in_ready}, 0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("t6_abort_accum", {29'd0, busy, out_valid, in_ready}, 0);
        repeat (2) @(negedge clk);
        chk("t6_abort_quiet", {30'd0, busy, out_valid}, 0);

        // Abort while the result is presented and out_ready is high.
        start = 1'b1; len = 8'd0; bias = 16'h4000;
        @(negedge clk);
        start = 1'b0;
        chk("t6_done_valid", {31'd0, out_valid}, 1);
        abort = 1'b1; out_ready = 1'b1;
        #1;
        chk("t6_abort_val", {15'd0, out_valid, out_data}, 0);
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        chk("t6_abort_done", {30'd0, busy, out_valid}, 0);

        // Reset in the middle of a job.
        start = 1'b1; len = 8'd2; bias = 16'h0000;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 32'h40404040; in_b = 32'h40404040;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_mid", {29'd0, busy, out_valid, in_ready}, 0);
        fill_const(1, 32'h40404040, 32'h40404040);
        run_job("t6_after", 16'h0000, 0, 0, 1'b0, 16'h5000);

        for (int j = 0; j < 25; j++) begin
            n = $urandom_range(1, 6);
            job_a.delete(); job_b.delete();
            for (int c = 0; c < n; c++) begin
                job_a.push_back({rand_p8(), rand_p8(), rand_p8(), rand_p8()});
                job_b.push_back({rand_p8(), rand_p8(), rand_p8(), rand_p8()});
            end
            b = rand_bias();
            e = model_job(b);
            run_job($sformatf("rnd%0d", j), b, 30, $urandom_range(0, 3), 1'b0, e);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
